// File: rtl/speed_ramp_pkg.sv
// speed_ramp_pkg
//   Shared definitions for the soft-start/soft-stop ramp controller:
//   the FSM state encoding (3-bit, legacy-compatible constants) and the
//   default speed-code width.
package speed_ramp_pkg;

    localparam int SPEED_W_DEF = 3;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] UP   = 3'd1;
    localparam logic [2:0] DOWN = 3'd2;
    localparam logic [2:0] HOLD = 3'd3;
    localparam logic [2:0] STOP = 3'd4;

endpackage : speed_ramp_pkg

// File: rtl/speed_ramp_step_timer.sv
// step_timer
//   Free-running interval counter for the ramp. Counts 0..STEP_CYCLES-1
//   while enabled and emits a one-cycle tick on the terminal count.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear back to 0 (wins over en)
//   en         : count enable
//   tick       : high during the cycle the count equals STEP_CYCLES-1
module step_timer #(
    parameter int STEP_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // tick is consumed by the parent FSM to form its next state; the
    // parent's outputs are all registered, so no input reaches an output
    // combinationally through this path.
    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : step_timer

// File: rtl/speed_ramp.sv
// speed_ramp
//   Soft-start/soft-stop controller driving a PWM generator's speed and
//   enable inputs. Walks the applied speed one code per STEP_CYCLES toward
//   the target, and ramps to zero before dropping pwm_en on shutdown.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : request output active
//   target     : desired speed code
//   speed      : applied speed code (registered)
//   pwm_en     : PWM generator enable (registered)
//   busy       : ramp in progress (UP, DOWN, STOP)
//   at_target  : holding speed == target with run high
module speed_ramp
    import speed_ramp_pkg::*;
#(
    parameter int SPEED_W     = SPEED_W_DEF,
    parameter int STEP_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic [SPEED_W-1:0] target,
    output logic [SPEED_W-1:0] speed,
    output logic               pwm_en,
    output logic               busy,
    output logic               at_target
);

    localparam logic [SPEED_W-1:0] ONE = SPEED_W'(1);

    logic [2:0]         state_q, state_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic               pwm_en_q, pwm_en_d;
    logic               busy_q, busy_d;
    logic               at_target_q, at_target_d;
    logic               tick;
    logic               timer_en;
    logic               timer_clr;

    // Direction implied by comparing the target with the applied speed.
    function automatic logic [2:0] dir_of(input logic [SPEED_W-1:0] tgt,
                                          input logic [SPEED_W-1:0] spd);
        if (tgt > spd)      return UP;
        else if (tgt < spd) return DOWN;
        else                return HOLD;
    endfunction

    assign timer_en  = (state_q == UP) || (state_q == DOWN) || (state_q == STOP);
    // Every state change restarts the interval; staying put keeps counting.
    assign timer_clr = (state_d != state_q);

    step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_step_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (timer_clr),
        .en   (timer_en),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        case (state_q)
            IDLE: begin
                if (run) state_d = (target == '0) ? HOLD : UP;
            end
            UP, DOWN, HOLD: begin
                if (!run) begin
                    // A step coinciding with the run fall is dropped.
                    state_d = STOP;
                end else if (state_q == UP && tick && speed_q < target) begin
                    // Step first; a fresh target is compared next cycle.
                    speed_d = speed_q + ONE;
                    state_d = (speed_d == target) ? HOLD : UP;
                end else if (state_q == DOWN && tick && speed_q > target) begin
                    speed_d = speed_q - ONE;
                    state_d = (speed_d == target) ? HOLD : DOWN;
                end else begin
                    state_d = dir_of(target, speed_q);
                end
            end
            STOP: begin
                if (run) begin
                    state_d = dir_of(target, speed_q);
                end else if (speed_q == '0) begin
                    state_d = IDLE;
                end else if (tick) begin
                    speed_d = speed_q - ONE;
                end
            end
            default: begin
                state_d = IDLE;
                speed_d = '0;
            end
        endcase
    end

    // Output flags decoded from the next state so they are flops aligned
    // with state_q rather than combinational decodes of it.
    always_comb begin
        pwm_en_d    = (state_d != IDLE);
        busy_d      = (state_d == UP) || (state_d == DOWN) || (state_d == STOP);
        at_target_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            speed_q     <= '0;
            pwm_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            at_target_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            speed_q     <= speed_d;
            pwm_en_q    <= pwm_en_d;
            busy_q      <= busy_d;
            at_target_q <= at_target_d;
        end
    end

    assign speed     = speed_q;
    assign pwm_en    = pwm_en_q;
    assign busy      = busy_q;
    assign at_target = at_target_q;

endmodule : speed_ramp

// File: tb/tb_speed_ramp.sv
// tb_speed_ramp
//   Directed checks of speed_ramp with STEP_CYCLES = 4, SPEED_W = 3.
//   "Edge k" is the k-th rising edge after the one at which stimulus was
//   applied; outputs are sampled 1 ns after each rising edge.
module tb_speed_ramp;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [2:0] target = 3'd0;
    logic [2:0] speed;
    logic       pwm_en, busy, at_target;

    int n_checks = 0;
    int n_fail   = 0;

    speed_ramp #(.SPEED_W(3), .STEP_CYCLES(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .target   (target),
        .speed    (speed),
        .pwm_en   (pwm_en),
        .busy     (busy),
        .at_target(at_target)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        run    = 1'b0;
        target = 3'd0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({speed, pwm_en, busy, at_target} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_idle: got speed=%0d en=%b busy=%b at=%b, want all 0",
                     speed, pwm_en, busy, at_target);
        end
        // Ramp to speed 3 (edge 13) then pull reset between edges.
        target = 3'd5; run = 1'b1;
        step(14);
        n_checks++;
        if (speed !== 3'd3) begin
            n_fail++; $display("FAIL reset_pre_speed: got %0d want 3", speed);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({speed, pwm_en, busy, at_target} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_async: got speed=%0d en=%b busy=%b at=%b, want all 0",
                     speed, pwm_en, busy, at_target);
        end
        run = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(5);
        n_checks++;
        if ({speed, pwm_en, busy, at_target} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got speed=%0d en=%b busy=%b at=%b, want all 0",
                     speed, pwm_en, busy, at_target);
        end
        $display("test_reset done");
    endtask

    task automatic test_ramp_up();
        int exp_spd;
        do_reset();
        target = 3'd5; run = 1'b1;
        for (int e = 1; e <= 21; e++) begin
            step(1);
            exp_spd = (e - 1) / 4;
            n_checks++;
            if (speed !== 3'(exp_spd) || pwm_en !== 1'b1 || busy !== (e < 21)
                || at_target !== (e >= 21)) begin
                n_fail++;
                $display("FAIL ramp_up edge %0d: got speed=%0d en=%b busy=%b at=%b, want speed=%0d en=1 busy=%b at=%b",
                         e, speed, pwm_en, busy, at_target, exp_spd, e < 21, e >= 21);
            end
        end
        $display("test_ramp_up done: speed=%0d", speed);
    endtask

    task automatic test_retarget();
        int exp_spd;
        do_reset();
        target = 3'd5; run = 1'b1;
        step(13);
        n_checks++;
        if (speed !== 3'd3) begin
            n_fail++; $display("FAIL retarget_pre: got %0d want 3", speed);
        end
        target = 3'd1;
        // Edge 1: DOWN with cleared counter; steps land on edges 5 and 9.
        for (int e = 1; e <= 9; e++) begin
            step(1);
            exp_spd = (e < 5) ? 3 : (e < 9) ? 2 : 1;
            n_checks++;
            if (speed !== 3'(exp_spd) || at_target !== (e == 9) || busy !== (e != 9)) begin
                n_fail++;
                $display("FAIL retarget edge %0d: got speed=%0d busy=%b at=%b, want speed=%0d busy=%b at=%b",
                         e, speed, busy, at_target, exp_spd, e != 9, e == 9);
            end
        end
        $display("test_retarget done: speed=%0d", speed);
    endtask

    task automatic test_soft_stop();
        int exp_spd;
        do_reset();
        target = 3'd5; run = 1'b1;
        step(21);
        run = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            step(1);
            exp_spd = (k >= 21) ? 0 : 5 - (k - 1) / 4;
            n_checks++;
            if (speed !== 3'(exp_spd) || pwm_en !== (k <= 21) || busy !== (k <= 21)
                || at_target !== 1'b0) begin
                n_fail++;
                $display("FAIL soft_stop edge %0d: got speed=%0d en=%b busy=%b at=%b, want speed=%0d en=%b busy=%b at=0",
                         k, speed, pwm_en, busy, at_target, exp_spd, k <= 21, k <= 21);
            end
        end
        $display("test_soft_stop done");
    endtask

    task automatic test_resume();
        int exp_spd;
        do_reset();
        target = 3'd4; run = 1'b1;
        step(17);
        run = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step(1);
            exp_spd = 4 - (k - 1) / 4;
            n_checks++;
            if (speed !== 3'(exp_spd) || pwm_en !== 1'b1) begin
                n_fail++;
                $display("FAIL resume_stop edge %0d: got speed=%0d en=%b, want speed=%0d en=1",
                         k, speed, pwm_en, exp_spd);
            end
        end
        target = 3'd6; run = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step(1);
            exp_spd = 2 + (k - 1) / 4;
            n_checks++;
            if (speed !== 3'(exp_spd) || pwm_en !== 1'b1 || at_target !== (k >= 17)) begin
                n_fail++;
                $display("FAIL resume_up edge %0d: got speed=%0d en=%b at=%b, want speed=%0d en=1 at=%b",
                         k, speed, pwm_en, at_target, exp_spd, k >= 17);
            end
        end
        $display("test_resume done: speed=%0d", speed);
    endtask

    task automatic test_edge_cases();
        do_reset();
        target = 3'd0; run = 1'b1;
        step(1);
        n_checks++;
        if (speed !== 3'd0 || pwm_en !== 1'b1 || at_target !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_target: got speed=%0d en=%b busy=%b at=%b, want 0 1 0 1",
                     speed, pwm_en, busy, at_target);
        end
        target = 3'd7;
        step(28);
        n_checks++;
        if (speed !== 3'd6 || at_target !== 1'b0) begin
            n_fail++;
            $display("FAIL max_pre: got speed=%0d at=%b, want 6 0", speed, at_target);
        end
        step(1);
        n_checks++;
        if (speed !== 3'd7 || at_target !== 1'b1) begin
            n_fail++;
            $display("FAIL max_reach: got speed=%0d at=%b, want 7 1", speed, at_target);
        end
        step(12);
        n_checks++;
        if (speed !== 3'd7 || at_target !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL max_nowrap: got speed=%0d busy=%b at=%b, want 7 0 1",
                     speed, busy, at_target);
        end
        // run falls exactly on a step edge: edge 9 would step 1 -> 2.
        do_reset();
        target = 3'd5; run = 1'b1;
        step(8);
        n_checks++;
        if (speed !== 3'd1) begin
            n_fail++; $display("FAIL stepfall_pre: got %0d want 1", speed);
        end
        run = 1'b0;
        step(1);
        n_checks++;
        if (speed !== 3'd1 || pwm_en !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stepfall_discard: got speed=%0d en=%b busy=%b, want 1 1 1",
                     speed, pwm_en, busy);
        end
        step(4);
        n_checks++;
        if (speed !== 3'd0 || pwm_en !== 1'b1) begin
            n_fail++;
            $display("FAIL stepfall_zero: got speed=%0d en=%b, want 0 1", speed, pwm_en);
        end
        step(1);
        n_checks++;
        if (pwm_en !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stepfall_idle: got en=%b busy=%b, want 0 0", pwm_en, busy);
        end
        $display("test_edge_cases done");
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_retarget();
        test_soft_stop();
        test_resume();
        test_edge_cases();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_speed_ramp
